band_power_meter: RTL and testbench

BAND_POWER_METER -- requirements
Module: band_power_meter

---
 rtl/band_power_meter.sv | 84 ++++++++
 tb/tb_band_power_meter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/band_power_meter.sv
// band_power_meter: windowed mean-square of a band signal handed to a square-root stage for RMS level
module band_power_meter #(
  parameter int WIN_LOG2 = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        smpl_vld,
  input  logic [15:0] smpl,
  input  logic        sq_done,
  input  logic [7:0]  sq_result,
  output logic [15:0] mag,
  output logic        sq_go,
  output logic [7:0]  level,
  output logic        level_vld,
  output logic        overrun
);
  typedef enum logic [1:0] {IDLE, RUN, WAIT} state_t;
  state_t state, state_nx;
  logic signed [15:0] s;
  logic signed [31:0] sq;
  logic p1_vld;
  logic [31:0] p1_prod;
  logic [31+WIN_LOG2:0] acc, total;
  logic [WIN_LOG2-1:0] cnt;
  logic close, cl_vld;
  logic [16:0] m;
  logic [15:0] cl_m;
  assign s = smpl;
  assign sq = s * s;
  assign total = acc + {{WIN_LOG2{1'b0}}, p1_prod};
  assign close = p1_vld && (cnt == '1);
  assign m = 17'(total >> (WIN_LOG2 + 14));
  // square each accepted sample into the P1 stage
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      p1_vld <= 1'b0;
      p1_prod <= '0;
    end else begin
      p1_vld <= smpl_vld;
      if (smpl_vld) p1_prod <= sq;
    end
  // accumulate products, closing the window when the count wraps
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (p1_vld) begin
      acc <= close ? '0 : total;
      cnt <= cnt + 1'b1;
    end
  // register the saturated window result for the handshake FSM
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cl_vld <= 1'b0;
      cl_m <= '0;
    end else begin
      cl_vld <= close;
      if (close) cl_m <= m[16] ? 16'hFFFF : m[15:0];
    end
  // handshake state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // next state and run request: RUN is a single cycle that ignores sq_done
  always_comb begin
    state_nx = state;
    sq_go = 1'b0;
    state_nx = state == IDLE ? (cl_vld ? RUN : IDLE) : state == RUN ? WAIT : (sq_done ? IDLE : WAIT);
    sq_go = state != IDLE;
  end
  // outputs: mag loads on IDLE->RUN, level on completion, overrun when a result arrives while busy
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mag <= '0;
      level <= '0;
      level_vld <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (state == IDLE && cl_vld) mag <= cl_m;
      if (state == WAIT && sq_done) level <= sq_result;
      level_vld <= state == WAIT && sq_done;
      overrun <= overrun | (cl_vld && state != IDLE);
    end
endmodule

// File: tb/tb_band_power_meter.sv
// tb_band_power_meter: randomized and directed checks of band_power_meter against a window-arithmetic model
module tb_band_power_meter;
  logic clk = 0, rst_n = 0;
  logic smpl_vld = 0, smpl_vld8 = 0;
  logic [15:0] smpl = 0, smpl8 = 0;
  logic sq_done, sq_done8;
  logic [7:0] sq_result, sq_result8;
  logic [15:0] mag, mag8;
  logic sq_go, sq_go8, level_vld, level_vld8, overrun, overrun8;
  logic [7:0] level, level8;
  int sc = 0, sc8 = 0, cyc = 0, errors = 0, checks = 0;

  band_power_meter #(.WIN_LOG2(2)) dut (.clk(clk), .rst_n(rst_n), .smpl_vld(smpl_vld), .smpl(smpl),
    .sq_done(sq_done), .sq_result(sq_result), .mag(mag), .sq_go(sq_go), .level(level),
    .level_vld(level_vld), .overrun(overrun));
  band_power_meter #(.WIN_LOG2(8)) dut8 (.clk(clk), .rst_n(rst_n), .smpl_vld(smpl_vld8), .smpl(smpl8),
    .sq_done(sq_done8), .sq_result(sq_result8), .mag(mag8), .sq_go(sq_go8), .level(level8),
    .level_vld(level_vld8), .overrun(overrun8));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] isqrt(input int v);
    int r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r[7:0];
  endfunction

  function automatic logic [15:0] exp_mag(input logic [15:0] q[$], input int w);
    longint acc = 0;
    foreach (q[i]) acc += longint'($signed(q[i])) * longint'($signed(q[i]));
    acc = acc / (longint'(1) << w) / 16384;
    return acc > 65535 ? 16'hFFFF : 16'(acc);
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin sc <= 0; sq_done <= 0; sq_result <= 0; end
    else if (!sq_go || sq_done) begin sc <= 0; sq_done <= 0; end
    else if (sc == 7) begin sq_done <= 1; sq_result <= isqrt(int'(mag)); end
    else sc <= sc + 1;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin sc8 <= 0; sq_done8 <= 0; sq_result8 <= 0; end
    else if (!sq_go8 || sq_done8) begin sc8 <= 0; sq_done8 <= 0; end
    else if (sc8 == 7) begin sq_done8 <= 1; sq_result8 <= isqrt(int'(mag8)); end
    else sc8 <= sc8 + 1;

  task automatic send(input logic [15:0] q[$], input bit gaps, output int t);
    foreach (q[i]) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1 smpl_vld = 0; end
      @(posedge clk); #1 smpl_vld = 1; smpl = q[i]; t = cyc;
    end
  endtask

  task automatic check_window(input string nm, input int t, input logic [15:0] me, input logic oe);
    int n = 0;
    @(posedge clk); #1 smpl_vld = 0;
    while (sq_go !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (sq_go !== 1'b1 || cyc - t != 3) begin errors++; $display("FAIL %s latency: got %0d want 3", nm, cyc - t); end
    checks++;
    if (mag !== me) begin errors++; $display("FAIL %s mag: got %h want %h", nm, mag, me); end
    n = 0;
    while (level_vld !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (level_vld !== 1'b1 || level !== isqrt(int'(me)))
      begin errors++; $display("FAIL %s level: got %h vld %b want %h", nm, level, level_vld, isqrt(int'(me))); end
    @(posedge clk); #1;
    checks++;
    if (level_vld !== 1'b0) begin errors++; $display("FAIL %s pulse: level_vld %b want 0", nm, level_vld); end
    checks++;
    if (overrun !== oe) begin errors++; $display("FAIL %s overrun: got %b want %b", nm, overrun, oe); end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({mag, sq_go, level, level_vld, overrun, mag8, sq_go8, level8, level_vld8, overrun8} !== '0)
      begin errors++; $display("FAIL reset outputs: mag %h go %b level %h vld %b ovr %b, want all 0", mag, sq_go, level, level_vld, overrun); end
    @(posedge clk); #1 rst_n = 1;
  endtask

  task automatic test_patterns;
    logic [15:0] pats[4] = '{16'h0100, 16'h4000, 16'hC000, 16'h8000};
    logic [15:0] want[4] = '{16'h0004, 16'h4000, 16'h4000, 16'hFFFF};
    logic [15:0] q[$];
    int t;
    foreach (pats[i]) begin
      q = {pats[i], pats[i], pats[i], pats[i]};
      checks++;
      if (exp_mag(q, 2) !== want[i]) begin errors++; $display("FAIL model %h: got %h want %h", pats[i], exp_mag(q, 2), want[i]); end
      send(q, 0, t);
      check_window($sformatf("pat_%h", pats[i]), t, want[i], 1'b0);
    end
  endtask

  task automatic test_random;
    logic [15:0] q[$];
    int t;
    for (int w = 0; w < 6; w++) begin
      q = {};
      for (int i = 0; i < 4; i++) q.push_back(16'($urandom));
      send(q, 1, t);
      check_window($sformatf("rand_%0d", w), t, exp_mag(q, 2), 1'b0);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] w1[$] = {16'h0100, 16'h0100, 16'h0100, 16'h0100};
    logic [15:0] w2[$] = {16'h4000, 16'h4000, 16'h4000, 16'h4000};
    logic [15:0] w3[$] = {16'h1234, 16'hEDCC, 16'h7000, 16'h0F0F};
    int t, n = 0;
    send(w1, 0, t);
    send(w2, 0, t);
    @(posedge clk); #1 smpl_vld = 0;
    while (level_vld !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    checks++;
    if (level_vld !== 1'b1 || level !== 8'h02) begin errors++; $display("FAIL b2b level: got %h vld %b want 02", level, level_vld); end
    checks++;
    if (mag !== 16'h0004) begin errors++; $display("FAIL b2b mag: got %h want 0004", mag); end
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL b2b overrun: got %b want 1", overrun); end
    send(w3, 0, t);
    check_window("b2b_win3", t, exp_mag(w3, 2), 1'b1);
  endtask

  task automatic test_reset_mid;
    logic [15:0] q[$] = {16'h0100, 16'hFF00, 16'h0000, 16'h0000};
    int t, n = 0;
    bit seen = 0;
    send(q, 0, t);
    @(posedge clk); #1 smpl_vld = 0;
    while (sq_go !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (mag !== 16'h0002) begin errors++; $display("FAIL mixed mag: got %h want 0002", mag); end
    repeat (3) @(posedge clk);
    #1 rst_n = 0;
    #1;
    checks++;
    if ({mag, sq_go, level, level_vld, overrun} !== '0)
      begin errors++; $display("FAIL midreset outputs: mag %h go %b level %h vld %b ovr %b, want all 0", mag, sq_go, level, level_vld, overrun); end
    @(posedge clk); #1 rst_n = 1;
    repeat (20) begin @(posedge clk); #1; if (level_vld || sq_go) seen = 1; end
    checks++;
    if (seen) begin errors++; $display("FAIL midreset stale: level_vld/sq_go seen %b want 0", seen); end
  endtask

  task automatic test_win8;
    int t = 0, n = 0;
    repeat (256) begin @(posedge clk); #1 smpl_vld8 = 1; smpl8 = 16'h7FFF; t = cyc; end
    @(posedge clk); #1 smpl_vld8 = 0;
    while (sq_go8 !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (sq_go8 !== 1'b1 || cyc - t != 3) begin errors++; $display("FAIL win8 latency: got %0d want 3", cyc - t); end
    checks++;
    if (mag8 !== 16'hFFFC) begin errors++; $display("FAIL win8 mag: got %h want fffc", mag8); end
    n = 0;
    while (level_vld8 !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (level_vld8 !== 1'b1 || level8 !== 8'hFF) begin errors++; $display("FAIL win8 level: got %h vld %b want ff", level8, level_vld8); end
    checks++;
    if (overrun8 !== 1'b0) begin errors++; $display("FAIL win8 overrun: got %b want 0", overrun8); end
  endtask

  initial begin
    test_reset;
    test_patterns;
    test_random;
    test_back_to_back;
    test_reset_mid;
    test_win8;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
